wh_bram_reader: RTL and testbench
=================================

// Module: wh_bram_reader
// PURPOSE
// - Consumer side of the WH BRAM. Reads WH entries {16 x result, num_of_nodes, source_node_flag} from port B.
// - Streams each entry to the attention stage over a valid/ready interface, framed per subgraph (sof/eof).
// - Never reads an entry the SpMM writer has not yet committed; tracks commits via a copy of the writer's write enable.
// PARAMETERS
// - WH_DATA_WIDTH   12                                 width of one result element
// - W_NUM_OF_COLS   16                                 result elements per entry
// - NUM_OF_NODES    168                                max nodes per subgraph
// - WH_DEPTH        242101                             WH BRAM depth = total entries per run
// - NUM_NODE_WIDTH  $clog2(NUM_OF_NODES)
// - RESULT_WIDTH    WH_DATA_WIDTH*W_NUM_OF_COLS
// - WH_WIDTH        RESULT_WIDTH+NUM_NODE_WIDTH+1
// - WH_ADDR_W       $clog2(WH_DEPTH)
// PORTS
// - clk                 in   1               clock, all logic on rising edge
// - rst                 in   1               synchronous reset, active-high
// - start_i             in   1               pulse: begin a read pass at address 0
// - wh_wr_en_i          in   1               writer commit strobe; 1 = one entry committed this cycle
// - WH_BRAM_dout        in   WH_WIDTH        port-B read data, valid 1 cycle after enb
// - WH_BRAM_enb         out  1               port-B read enable
// - WH_BRAM_addrb       out  WH_ADDR_W       port-B read address
// - wh_valid_o          out  1               output entry valid
// - wh_ready_i          in   1               downstream accepts entry
// - wh_data_o           out  RESULT_WIDTH    16 results, result_1 in MSBs
// - wh_num_of_nodes_o   out  NUM_NODE_WIDTH  node count of the current subgraph
// - wh_sof_o            out  1               first entry of subgraph (source_node_flag)
// - wh_eof_o            out  1               last entry of subgraph
// - done_o              out  1               pass complete; held until next start_i
// - framing_err_o       out  1               sticky framing error (see CONFIGURATION)
// BEHAVIOUR
// - Reset: every output 0; FSM=IDLE; addr, avail, in-flight, buffer and node counters cleared.
// - FSM states:
//   - IDLE  -> RUN on start_i.
//   - RUN   -> DRAIN when issued count == WH_DEPTH.
//   - DRAIN -> DONE when buffer empty and no read in flight.
//   - DONE  -> RUN on start_i: clears addr/issued/err, keeps avail. start_i is ignored in RUN and DRAIN.
// - avail = committed minus issued:
//   - +1 on wh_wr_en_i; -1 on issue; both in one cycle = unchanged.
//   - Writer cannot exceed WH_DEPTH, so avail does not saturate.
// - Issue (enb=1) in RUN only when avail>0 and (buffered + in_flight) < 2.
//   - addrb increments per issue and wraps WH_DEPTH-1 -> 0.
// - Read latency 1 cycle: data is captured into a 2-entry skid FIFO the cycle after enb.
//   - The FIFO can never overflow under backpressure.
// - Output stream:
//   - wh_valid_o = FIFO non-empty; transfer when wh_valid_o && wh_ready_i.
//   - While valid and not ready: valid and all data outputs held stable.
// - Minimum latency: enb at cycle T, wh_valid_o at T+2. Sustained throughput is 1 entry/cycle with ready=1.
// - Framing, evaluated at the output head:
//   - flag=1: sof=1; node counter loads num_of_nodes; wh_num_of_nodes_o = field.
//   - Otherwise wh_num_of_nodes_o = latched value.
//   - eof=1 when the remaining count == 1, including num_of_nodes==1 (sof=eof=1).
//   - Counter decrements on each transfer.
// - done_o: 1 in DONE, 0 elsewhere.
// - rst mid-pass: everything is discarded; the next pass needs start_i.
// CONFIGURATION
// - WH_RD_CHECK_EN defined: framing_err_o is set and held on any of:
//   - flag=1 while the node counter != 0
//   - flag=1 with num_of_nodes==0
//   - flag=0 while the node counter == 0
//   Cleared by rst or start_i. The stream is unaffected.
// - WH_RD_CHECK_EN undefined: framing_err_o tied 0; no check logic is built.
// TESTING
// - Commit 3 entries {flag=1,n=3},{0,3},{0,3}; start_i; ready=1
//   -> 3 transfers: sof on #1 only, eof on #3 only, num_of_nodes=3 on all.
// - start_i with avail=0
//   -> enb stays 0. A wh_wr_en_i pulse then gives enb the next cycle and valid 2 cycles later.
// - Commit 10 entries, ready low for 20 cycles, then high
//   -> at most 2 reads issued while stalled; 10 entries in order, none lost or duplicated.
// - Single-node subgraph {1,1} followed by {1,2},{0,2}
//   -> first entry sof=eof=1; next pair framed sof/eof.
// - WH_DEPTH=4 build, two passes
//   -> addrb sequence 0..3 then 0..3; done_o after 4th transfer, cleared by start_i.
// - WH_RD_CHECK_EN: entries {1,3},{1,2}
//   -> framing_err_o=1 from the 2nd entry until start_i. Without the macro it stays 0.

Source files
------------

// File: rtl/wh_bram_reader.sv
// wh_bram_reader
// Consumer side of the WH BRAM. Issues port-B reads only for entries the
// SpMM writer has already committed, buffers the 1-cycle-latency read data in
// a 2-entry skid FIFO and streams entries downstream over valid/ready, framed
// per subgraph with sof/eof and the subgraph node count.
// Optional build macro: WH_RD_CHECK_EN adds the sticky framing checker that
// drives framing_err_o; without it framing_err_o is tied low.
module wh_bram_reader #(
   parameter int WH_DATA_WIDTH  = 12,
   parameter int W_NUM_OF_COLS  = 16,
   parameter int NUM_OF_NODES   = 168,
   parameter int WH_DEPTH       = 242101,
   parameter int NUM_NODE_WIDTH = $clog2(NUM_OF_NODES),
   parameter int RESULT_WIDTH   = WH_DATA_WIDTH * W_NUM_OF_COLS,
   parameter int WH_WIDTH       = RESULT_WIDTH + NUM_NODE_WIDTH + 1,
   parameter int WH_ADDR_W      = $clog2(WH_DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
   input  logic                      wh_wr_en_i,
   input  logic [WH_WIDTH-1:0]       WH_BRAM_dout,
   output logic                      WH_BRAM_enb,
   output logic [WH_ADDR_W-1:0]      WH_BRAM_addrb,
   output logic                      wh_valid_o,
   input  logic                      wh_ready_i,
   output logic [RESULT_WIDTH-1:0]   wh_data_o,
   output logic [NUM_NODE_WIDTH-1:0] wh_num_of_nodes_o,
   output logic                      wh_sof_o,
   output logic                      wh_eof_o,
   output logic                      done_o,
   output logic                      framing_err_o
);

   localparam int                   CNT_W     = $clog2(WH_DEPTH + 1);
   localparam logic [CNT_W-1:0]     DEPTH_C   = CNT_W'(WH_DEPTH);
   localparam logic [WH_ADDR_W-1:0] LAST_ADDR = WH_ADDR_W'(WH_DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state, state_nxt;

   // read-side bookkeeping
   logic [WH_ADDR_W-1:0] addr;
   logic [CNT_W-1:0]     issued;
   logic [CNT_W-1:0]     avail;
   logic                 start_acc;
   logic                 issue;

   // read pipeline and skid FIFO
   logic                 rd_vld_p1;
   logic [WH_WIDTH-1:0]  fifo_mem [2];
   logic                 wr_ptr;
   logic                 rd_ptr;
   logic [1:0]           fifo_cnt;
   logic [1:0]           occ_nxt;
   logic                 fifo_nonempty;
   logic                 pop;

   // output head and framing
   logic [WH_WIDTH-1:0]       head;
   logic                      head_flag;
   logic [NUM_NODE_WIDTH-1:0] head_n;
   logic [NUM_NODE_WIDTH-1:0] remaining;
   logic [NUM_NODE_WIDTH-1:0] node_cnt;
   logic [NUM_NODE_WIDTH-1:0] nodes_lat;

   // FIFO occupancy after this cycle's transfer plus the read already in
   // flight; counting the departing head keeps 1 entry/cycle with ready=1
   // while still never letting more than two entries be owed to the FIFO.
   assign fifo_nonempty = (fifo_cnt != 2'd0);
   assign pop           = fifo_nonempty && wh_ready_i;
   assign occ_nxt       = fifo_cnt + {1'b0, rd_vld_p1} - {1'b0, pop};

   assign issue = (state == RUN) && (avail != '0) && (issued != DEPTH_C)
                  && (occ_nxt < 2'd2);

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic; start_i only acts from IDLE or DONE
   always_comb begin
      state_nxt = state;
      start_acc = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) begin
               state_nxt = RUN;
               start_acc = 1'b1;
            end
         end
         RUN: begin
            if (issued == DEPTH_C) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (!fifo_nonempty && !rd_vld_p1) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (start_i) begin
               state_nxt = RUN;
               start_acc = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // read address, issued count and committed-but-unread count
   always_ff @(posedge clk) begin
      if (rst) begin
         addr   <= '0;
         issued <= '0;
         avail  <= '0;
      end else begin
         if (start_acc) begin
            addr   <= '0;
            issued <= '0;
         end else if (issue) begin
            addr   <= (addr == LAST_ADDR) ? '0 : addr + WH_ADDR_W'(1);
            issued <= issued + CNT_W'(1);
         end
         case ({wh_wr_en_i, issue})
            2'b10:   avail <= avail + CNT_W'(1);
            2'b01:   avail <= avail - CNT_W'(1);
            default: avail <= avail;
         endcase
      end
   end

   // ---- stage p1: BRAM read data returns one cycle after enb ----
   // track the read in flight so its data is captured on return
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vld_p1 <= 1'b0;
      end else begin
         rd_vld_p1 <= issue;
      end
   end

   // skid FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         if (rd_vld_p1) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         fifo_cnt <= occ_nxt;
      end
   end

   // skid FIFO storage, written with the returning read data
   always_ff @(posedge clk) begin
      if (rd_vld_p1) begin
         fifo_mem[wr_ptr] <= WH_BRAM_dout;
      end
   end

   // ---- stage p2: FIFO head presented downstream ----
   assign head      = fifo_mem[rd_ptr];
   assign head_flag = head[0];
   assign head_n    = head[NUM_NODE_WIDTH:1];
   assign remaining = head_flag ? head_n : node_cnt;

   // remaining-node counter and latched subgraph size, advanced per transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         node_cnt  <= '0;
         nodes_lat <= '0;
      end else if (pop) begin
         node_cnt <= (remaining == '0) ? '0 : remaining - NUM_NODE_WIDTH'(1);
         if (head_flag) begin
            nodes_lat <= head_n;
         end
      end
   end

   assign wh_valid_o        = fifo_nonempty;
   assign wh_data_o         = fifo_nonempty ? head[WH_WIDTH-1 -: RESULT_WIDTH] : '0;
   assign wh_num_of_nodes_o = (fifo_nonempty && head_flag) ? head_n : nodes_lat;
   assign wh_sof_o          = fifo_nonempty && head_flag;
   assign wh_eof_o          = fifo_nonempty && (remaining == NUM_NODE_WIDTH'(1));
   assign done_o            = (state == DONE);
   assign WH_BRAM_enb       = issue;
   assign WH_BRAM_addrb     = addr;

`ifdef WH_RD_CHECK_EN
   logic err_q;
   logic err_hit;

   // a head entry contradicts the framing implied by the entries before it
   assign err_hit = fifo_nonempty &&
                    ((head_flag && (node_cnt != '0)) ||
                     (head_flag && (head_n == '0)) ||
                     (!head_flag && (node_cnt == '0)));

   // sticky framing error, cleared when a new pass starts
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (start_acc) begin
         err_q <= 1'b0;
      end else if (err_hit) begin
         err_q <= 1'b1;
      end
   end

   assign framing_err_o = err_q;
`else
   assign framing_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wh_bram_reader.sv
// tb_wh_bram_reader
// Randomized scoreboard bench for wh_bram_reader (WH_DEPTH=16 build).
// The stimulus commits entries into a BRAM model and pushes the expected
// output entry, computed from the subgraph framing rules, into a queue; a
// monitor pops and compares on every transfer and checks hold stability and
// the read address sequence.
`timescale 1ns/1ps
module tb_wh_bram_reader;
   localparam int DW = 12;
   localparam int NC = 16;
   localparam int NN = 168;
   localparam int D  = 16;
   localparam int NW = $clog2(NN);
   localparam int RW = DW * NC;
   localparam int WW = RW + NW + 1;
   localparam int AW = $clog2(D);

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic          wh_wr_en_i;
   logic [WW-1:0] WH_BRAM_dout;
   logic          WH_BRAM_enb;
   logic [AW-1:0] WH_BRAM_addrb;
   logic          wh_valid_o;
   logic          wh_ready_i;
   logic [RW-1:0] wh_data_o;
   logic [NW-1:0] wh_num_of_nodes_o;
   logic          wh_sof_o;
   logic          wh_eof_o;
   logic          done_o;
   logic          framing_err_o;

   always #5 clk = ~clk;

   wh_bram_reader #(
      .WH_DATA_WIDTH (DW),
      .W_NUM_OF_COLS (NC),
      .NUM_OF_NODES  (NN),
      .WH_DEPTH      (D)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .start_i           (start_i),
      .wh_wr_en_i        (wh_wr_en_i),
      .WH_BRAM_dout      (WH_BRAM_dout),
      .WH_BRAM_enb       (WH_BRAM_enb),
      .WH_BRAM_addrb     (WH_BRAM_addrb),
      .wh_valid_o        (wh_valid_o),
      .wh_ready_i        (wh_ready_i),
      .wh_data_o         (wh_data_o),
      .wh_num_of_nodes_o (wh_num_of_nodes_o),
      .wh_sof_o          (wh_sof_o),
      .wh_eof_o          (wh_eof_o),
      .done_o            (done_o),
      .framing_err_o     (framing_err_o)
   );

   // BRAM port-B model: data one cycle after enb
   logic [WW-1:0] bram [D];
   always @(posedge clk) begin
      if (WH_BRAM_enb) WH_BRAM_dout <= bram[WH_BRAM_addrb];
   end

   typedef struct packed {
      logic [RW-1:0] data;
      logic [NW-1:0] n;
      logic          sof;
      logic          eof;
   } exp_t;

   exp_t exp_q[$];
   exp_t held;
   exp_t e;
   logic hold = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   wptr = 0;
   int   m_rem = 0;
   int   m_lat = 0;
   bit   m_err = 1'b0;
   int   exp_addr = 0;
   int   cyc = 0;
   bit   stall_win = 1'b0;
   int   stall_issues = 0;
   int   n_xfer = 0;
   int   first_xfer = 0;
   int   last_xfer = 0;
   bit   gflag [16];
   int   gn [16];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // commit one entry: write the BRAM, pulse the commit strobe and queue
   // the response the framing rules predict for it
   task automatic commit(input bit flag, input int n);
      logic [RW-1:0] d;
      exp_t x;
      int r;
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bram[wptr] = {d, NW'(n), flag};
      wptr = (wptr + 1) % D;
      if (flag) begin
         if (m_rem != 0 || n == 0) m_err = 1'b1;
         r = n;
         m_lat = n;
      end else begin
         if (m_rem == 0) m_err = 1'b1;
         r = m_rem;
      end
      x.data = d;
      x.n    = NW'(m_lat);
      x.sof  = flag;
      x.eof  = (r == 1);
      m_rem  = (r == 0) ? 0 : r - 1;
      exp_q.push_back(x);
      wh_wr_en_i = 1'b1;
      tick(1);
      wh_wr_en_i = 1'b0;
   endtask

   // legal random subgraph framing for cnt entries
   task automatic gen(input int cnt);
      int left, i, sz;
      left = cnt;
      i = 0;
      while (left > 0) begin
         sz = $urandom_range(1, 6);
         if (sz > left) sz = left;
         for (int k = 0; k < sz; k++) begin
            gflag[i] = (k == 0);
            gn[i]    = (k == 0) ? sz : $urandom_range(0, 255);
            i++;
         end
         left -= sz;
      end
   endtask

   task automatic do_start();
      m_err = 1'b0;
      start_i = 1'b1;
      tick(1);
      start_i = 1'b0;
      chk("done_cleared_by_start", done_o, 1'b0);
   endtask

   task automatic wait_empty(input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 1000) begin
         tick(1);
         k++;
      end
      chk(name, exp_q.size(), 0);
   endtask

   task automatic end_pass(input string name, input bit rnd);
      int k;
      logic exp_err;
      k = 0;
      while (!done_o && k < 2000) begin
         wh_ready_i = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
         tick(1);
         k++;
      end
      wh_ready_i = 1'b1;
      chk({name, "_done"}, done_o, 1'b1);
      chk({name, "_all_out"}, exp_q.size(), 0);
`ifdef WH_RD_CHECK_EN
      exp_err = m_err;
`else
      exp_err = 1'b0;
`endif
      chk({name, "_framing_err"}, framing_err_o, exp_err);
   endtask

   task automatic rand_pass(input string name);
      int idx;
      gen(D);
      do_start();
      idx = 0;
      while (idx < D) begin
         wh_ready_i = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) != 0) begin
            commit(gflag[idx], gn[idx]);
            idx++;
         end else begin
            tick(1);
         end
      end
      end_pass(name, 1'b1);
   endtask

   initial begin
      rst = 1'b1;
      start_i = 1'b0;
      wh_wr_en_i = 1'b0;
      wh_ready_i = 1'b0;
      fork
         begin : stimulus
            tick(3);
            rst = 1'b0;
            tick(1);
            chk("rst_valid", wh_valid_o, 1'b0);
            chk("rst_enb", WH_BRAM_enb, 1'b0);
            chk("rst_addrb", WH_BRAM_addrb, 0);
            chk("rst_done", done_o, 1'b0);
            chk("rst_err", framing_err_o, 1'b0);
            chk("rst_sof_eof", {wh_sof_o, wh_eof_o}, 2'b00);
            chk("rst_data", wh_data_o, 0);
            chk("rst_nodes", wh_num_of_nodes_o, 0);

            // pass 1: start with nothing committed, then single-entry latency
            wh_ready_i = 1'b1;
            do_start();
            for (int i = 0; i < 4; i++) begin
               chk("enb_no_avail", WH_BRAM_enb, 1'b0);
               tick(1);
            end
            commit(1'b1, 3);
            chk("enb_after_commit", WH_BRAM_enb, 1'b1);
            tick(1);
            chk("valid_lat_t1", wh_valid_o, 1'b0);
            tick(1);
            chk("valid_lat_t2", wh_valid_o, 1'b1);
            commit(1'b0, 3);
            commit(1'b0, 3);
            wait_empty("first_subgraph_drained");

            // backpressure: 10 entries committed while ready is low
            wh_ready_i = 1'b0;
            stall_issues = 0;
            stall_win = 1'b1;
            commit(1'b1, 1);
            commit(1'b1, 2);
            commit(1'b0, 2);
            commit(1'b1, 7);
            for (int i = 0; i < 6; i++) commit(1'b0, 7);
            tick(20);
            stall_win = 1'b0;
            chk("stall_reads_le2", (stall_issues <= 2), 1'b1);
            chk("stall_valid", wh_valid_o, 1'b1);
            begin
               int k;
               k = 0;
               while (exp_q.size() != 0 && k < 1000) begin
                  wh_ready_i = ($urandom_range(0, 1) == 1);
                  tick(1);
                  k++;
               end
               chk("stall_drained", exp_q.size(), 0);
            end
            wh_ready_i = 1'b1;
            commit(1'b1, 3);
            commit(1'b0, 3);
            commit(1'b0, 3);
            end_pass("pass1", 1'b0);

            // pass 2: all entries committed while DONE, full-rate drain
            gen(D);
            for (int i = 0; i < D; i++) commit(gflag[i], gn[i]);
            chk("done_held", done_o, 1'b1);
            chk("no_valid_in_done", wh_valid_o, 1'b0);
            n_xfer = 0;
            do_start();
            end_pass("pass2", 1'b0);
            chk("pass2_xfers", n_xfer, D);
            chk("pass2_throughput", last_xfer - first_xfer, D - 1);

            // randomized passes
            rand_pass("pass3");
            rand_pass("pass4");

            // framing error pass: {1,3} followed by {1,2}
            do_start();
            commit(1'b1, 3);
            commit(1'b1, 2);
            commit(1'b0, 2);
            gen(D - 3);
            for (int i = 0; i < D - 3; i++) commit(gflag[i], gn[i]);
            end_pass("pass_err", 1'b1);
            do_start();
            chk("err_cleared_by_start", framing_err_o, 1'b0);
            gen(D);
            for (int i = 0; i < D; i++) commit(gflag[i], gn[i]);
            end_pass("pass_after_err", 1'b1);

            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
         begin : monitor
            forever begin
               @(negedge clk);
               cyc++;
               if (!rst) begin
                  if (WH_BRAM_enb) begin
                     chk("addrb_seq", WH_BRAM_addrb, exp_addr);
                     exp_addr = (exp_addr + 1) % D;
                     if (stall_win) stall_issues++;
                  end
                  if (hold) begin
                     chk("hold_valid", wh_valid_o, 1'b1);
                     chk("hold_data", wh_data_o, held.data);
                     chk("hold_nodes", wh_num_of_nodes_o, held.n);
                     chk("hold_sof_eof", {wh_sof_o, wh_eof_o}, {held.sof, held.eof});
                  end
                  hold = 1'b0;
                  if (wh_valid_o) begin
                     if (!wh_ready_i) begin
                        hold = 1'b1;
                        held = {wh_data_o, wh_num_of_nodes_o, wh_sof_o, wh_eof_o};
                     end else if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_xfer actual=entry required=none");
                     end else begin
                        e = exp_q.pop_front();
                        chk("xfer_data", wh_data_o, e.data);
                        chk("xfer_nodes", wh_num_of_nodes_o, e.n);
                        chk("xfer_sof", wh_sof_o, e.sof);
                        chk("xfer_eof", wh_eof_o, e.eof);
                        if (n_xfer == 0) first_xfer = cyc;
                        last_xfer = cyc;
                        n_xfer++;
                     end
                  end
               end
            end
         end
         begin : watchdog
            #2000000;
            $display("FAIL timeout actual=running required=finished");
            $fatal(1, "timeout");
         end
      join_any
   end

endmodule
